// File: rtl/cv32e40x_xif_offload_if.sv
// XIF issue/commit/result channels between the core-side offload initiator
// (master) and an eXtension-interface coprocessor (slave).
interface cv32e40x_xif_offload_if #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFR_WIDTH = 32
);
    logic                     issue_valid;
    logic                     issue_ready;
    logic [31:0]              issue_instr;
    logic [X_ID_WIDTH-1:0]    issue_id;
    logic [3*X_RFR_WIDTH-1:0] issue_rs;
    logic [2:0]               issue_rs_valid;
    logic                     issue_accept;
    logic                     issue_writeback;

    logic                     commit_valid;
    logic [X_ID_WIDTH-1:0]    commit_id;
    logic                     commit_kill;

    logic                     result_valid;
    logic                     result_ready;
    logic [X_ID_WIDTH-1:0]    result_id;
    logic [X_RFR_WIDTH-1:0]   result_data;
    logic [4:0]               result_rd;
    logic                     result_we;

    modport master (
        output issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
        input  issue_ready, issue_accept, issue_writeback,
        output commit_valid, commit_id, commit_kill,
        input  result_valid, result_id, result_data, result_rd, result_we,
        output result_ready
    );

    modport slave (
        input  issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
        output issue_ready, issue_accept, issue_writeback,
        input  commit_valid, commit_id, commit_kill,
        output result_valid, result_id, result_data, result_rd, result_we,
        input  result_ready
    );
endinterface

// File: rtl/cv32e40x_xif_offload.sv
// Core-side XIF initiator: issues offload requests, commits/kills in order and
// registers coprocessor results for writeback. CV32E40X_XIF_OFFLOAD_RESULT_CHECK_EN
// enables result-id checking and the sticky err_o.
//
// state | meaning
// IDLE  | ready for a pipeline request (if a table slot is free)
// ISSUE | presenting the latched request on the XIF issue channel
module cv32e40x_xif_offload #(
    parameter int unsigned X_ID_WIDTH      = 4,
    parameter int unsigned X_RFR_WIDTH     = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [31:0]              req_instr_i,
    input  logic [3*X_RFR_WIDTH-1:0] req_rs_i,
    input  logic [2:0]               req_rs_valid_i,
    output logic                     req_reject_o,
    input  logic                     core_commit_valid_i,
    input  logic                     core_commit_kill_i,
    cv32e40x_xif_offload_if.master   xif,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [4:0]               wb_rd_o,
    output logic [X_RFR_WIDTH-1:0]   wb_data_o,
    output logic [X_ID_WIDTH-1:0]    wb_id_o,
    output logic                     err_o
);
    localparam int unsigned NSLOT = MAX_OUTSTANDING;
`ifdef CV32E40X_XIF_OFFLOAD_RESULT_CHECK_EN
    localparam bit RES_CHECK = 1'b1;
`else
    localparam bit RES_CHECK = 1'b0;
`endif

    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state_q, state_d;

    logic                  req_hs, iss_hs, res_hs, alloc, do_commit, fwd;
    logic [X_ID_WIDTH-1:0] next_id_q;

    // Slot 0 is always the oldest entry; the table is kept compacted.
    logic                  slot_vld_q [NSLOT];
    logic [X_ID_WIDTH-1:0] slot_id_q  [NSLOT];
    logic                  slot_cmt_q [NSLOT];
    logic                  slot_wb_q  [NSLOT];
    logic                  slot_vld_d [NSLOT];
    logic [X_ID_WIDTH-1:0] slot_id_d  [NSLOT];
    logic                  slot_cmt_d [NSLOT];
    logic                  slot_wb_d  [NSLOT];
    logic                  keep       [NSLOT];
    logic                  cmt_upd    [NSLOT];
    int unsigned           rank       [NSLOT];

    int unsigned           occ, kept, cmt_idx, res_idx;
    logic                  cmt_hit, res_hit;
    logic [X_ID_WIDTH-1:0] cmt_id;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        req_hs      = 1'b0;
        iss_hs      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = (occ < NSLOT);
                if (req_valid_i && req_ready_o) begin
                    req_hs  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (xif.issue_ready) begin
                    iss_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign xif.issue_valid  = (state_q == ISSUE);
    assign xif.result_ready = !wb_valid_o || wb_ready_i;
    assign res_hs           = xif.result_valid && xif.result_ready;
    assign alloc            = iss_hs && xif.issue_accept;
    assign do_commit        = core_commit_valid_i && cmt_hit;
    assign fwd              = res_hs && xif.result_we && (res_hit || !RES_CHECK);

    always_comb begin
        occ     = 0;
        cmt_hit = 1'b0;
        cmt_idx = 0;
        cmt_id  = '0;
        res_hit = 1'b0;
        res_idx = 0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (slot_vld_q[i]) occ = occ + 1;
            if (slot_vld_q[i] && !slot_cmt_q[i] && !cmt_hit) begin
                cmt_hit = 1'b1;
                cmt_idx = i;
                cmt_id  = slot_id_q[i];
            end
            if (slot_vld_q[i] && (slot_id_q[i] == xif.result_id) && !res_hit &&
                (!RES_CHECK || (slot_cmt_q[i] && slot_wb_q[i]))) begin
                res_hit = 1'b1;
                res_idx = i;
            end
        end

        kept = 0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            keep[i]    = slot_vld_q[i];
            cmt_upd[i] = slot_cmt_q[i];
            if (res_hs && res_hit && (i == res_idx)) keep[i] = 1'b0;
            if (do_commit && (i == cmt_idx)) begin
                if (core_commit_kill_i || !slot_wb_q[i]) keep[i]    = 1'b0;
                else                                     cmt_upd[i] = 1'b1;
            end
            rank[i] = kept;
            if (keep[i]) kept = kept + 1;
        end

        // Survivors shift down to close gaps; a newly accepted entry lands behind them.
        for (int unsigned j = 0; j < NSLOT; j++) begin
            slot_vld_d[j] = 1'b0;
            slot_id_d[j]  = '0;
            slot_cmt_d[j] = 1'b0;
            slot_wb_d[j]  = 1'b0;
            for (int unsigned i = 0; i < NSLOT; i++) begin
                if (keep[i] && (rank[i] == j)) begin
                    slot_vld_d[j] = 1'b1;
                    slot_id_d[j]  = slot_id_q[i];
                    slot_cmt_d[j] = cmt_upd[i];
                    slot_wb_d[j]  = slot_wb_q[i];
                end
            end
            if (alloc && (j == kept)) begin
                slot_vld_d[j] = 1'b1;
                slot_id_d[j]  = xif.issue_id;
                slot_cmt_d[j] = 1'b0;
                slot_wb_d[j]  = xif.issue_writeback;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                slot_vld_q[i] <= 1'b0;
                slot_id_q[i]  <= '0;
                slot_cmt_q[i] <= 1'b0;
                slot_wb_q[i]  <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                slot_vld_q[i] <= slot_vld_d[i];
                slot_id_q[i]  <= slot_id_d[i];
                slot_cmt_q[i] <= slot_cmt_d[i];
                slot_wb_q[i]  <= slot_wb_d[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            next_id_q          <= '0;
            xif.issue_instr    <= '0;
            xif.issue_id       <= '0;
            xif.issue_rs       <= '0;
            xif.issue_rs_valid <= '0;
            req_reject_o       <= 1'b0;
            xif.commit_valid   <= 1'b0;
            xif.commit_id      <= '0;
            xif.commit_kill    <= 1'b0;
            wb_valid_o         <= 1'b0;
            wb_rd_o            <= '0;
            wb_data_o          <= '0;
            wb_id_o            <= '0;
        end else begin
            if (req_hs) begin
                xif.issue_instr    <= req_instr_i;
                xif.issue_id       <= next_id_q;
                xif.issue_rs       <= req_rs_i;
                xif.issue_rs_valid <= req_rs_valid_i;
            end
            if (alloc) next_id_q <= next_id_q + 1'b1;
            req_reject_o     <= iss_hs && !xif.issue_accept;
            xif.commit_valid <= do_commit;
            if (do_commit) begin
                xif.commit_id   <= cmt_id;
                xif.commit_kill <= core_commit_kill_i;
            end
            if (fwd) begin
                wb_valid_o <= 1'b1;
                wb_rd_o    <= xif.result_rd;
                wb_data_o  <= xif.result_data;
                wb_id_o    <= xif.result_id;
            end else if (wb_ready_i) begin
                wb_valid_o <= 1'b0;
            end
        end
    end

`ifdef CV32E40X_XIF_OFFLOAD_RESULT_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)                                        err_o <= 1'b0;
        else if ((res_hs && !res_hit) ||
                 (core_commit_valid_i && !cmt_hit))        err_o <= 1'b1;
    end
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_cv32e40x_xif_offload.sv
// Bench for cv32e40x_xif_offload: vector table plus hand sequences, with
// commit and writeback outputs checked against scoreboard queues.
module tb_cv32e40x_xif_offload;
    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_instr_i = '0;
    logic [95:0] req_rs_i = '0;
    logic [2:0]  req_rs_valid_i = '0;
    logic        req_reject_o;
    logic        core_commit_valid_i = 1'b0;
    logic        core_commit_kill_i = 1'b0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b1;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic [3:0]  wb_id_o;
    logic        err_o;

    cv32e40x_xif_offload_if #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32)) xif ();

    cv32e40x_xif_offload #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_instr_i(req_instr_i),
        .req_rs_i(req_rs_i), .req_rs_valid_i(req_rs_valid_i), .req_reject_o(req_reject_o),
        .core_commit_valid_i(core_commit_valid_i), .core_commit_kill_i(core_commit_kill_i),
        .xif(xif),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .wb_id_o(wb_id_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [3:0] id; logic kill; } cmt_t;
    typedef struct { logic [3:0] id; logic [4:0] rd; logic [31:0] data; } wb_t;
    typedef struct {
        logic [31:0] instr; logic [31:0] rs1, rs2, rs3; logic [2:0] rsv;
        bit accept; bit wb; int delay; bit kill;
        logic [31:0] data; logic [4:0] rd; bit we;
        bit exp_reject; bit exp_wb;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    cmt_t exp_cmt_q[$];
    wb_t  exp_wb_q[$];
    logic [3:0] unc_q[$];
    logic [3:0] exp_next_id = '0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    initial begin
        cmt_t c;
        wb_t  w;
        forever begin
            @(negedge clk_i);
            if (rst_n) begin
                if (xif.commit_valid) begin
                    if (exp_cmt_q.size() == 0) begin
                        check("commit_spurious", {xif.commit_kill, xif.commit_id}, 128'hFFFF);
                    end else begin
                        c = exp_cmt_q.pop_front();
                        check("commit_id", xif.commit_id, c.id);
                        check("commit_kill", xif.commit_kill, c.kill);
                    end
                end
                if (wb_valid_o && wb_ready_i) begin
                    if (exp_wb_q.size() == 0) begin
                        check("wb_spurious", {wb_id_o, wb_rd_o, wb_data_o}, 128'hFFFF_FFFF_FFFF);
                    end else begin
                        w = exp_wb_q.pop_front();
                        check("wb_data", wb_data_o, w.data);
                        check("wb_rd", wb_rd_o, w.rd);
                        check("wb_id", wb_id_o, w.id);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic model_reset();
        exp_next_id = '0;
        unc_q.delete();
        exp_cmt_q.delete();
        exp_wb_q.delete();
    endtask

    task automatic apply_reset();
        @(posedge clk_i); #1;
        rst_n = 1'b0;
        req_valid_i = 1'b0; core_commit_valid_i = 1'b0; wb_ready_i = 1'b1;
        xif.issue_ready = 1'b0; xif.issue_accept = 1'b0; xif.issue_writeback = 1'b0;
        xif.result_valid = 1'b0; xif.result_id = '0; xif.result_data = '0;
        xif.result_rd = '0; xif.result_we = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_request(input logic [31:0] instr, input logic [95:0] rs, input logic [2:0] rsv);
        bit ok = 0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b1; req_instr_i = instr; req_rs_i = rs; req_rs_valid_i = rsv;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_i);
            if (req_ready_o) begin ok = 1; break; end
        end
        if (!ok) check("req_timeout", 0, 1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic do_issue(input bit accept, input bit wb, input int delay,
                            input logic [31:0] instr, input logic [95:0] rs, input logic [2:0] rsv);
        bit ok = 0;
        bit stable = 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_i);
            if (xif.issue_valid) begin ok = 1; break; end
        end
        if (!ok) check("issue_timeout", 0, 1);
        check("issue_id", xif.issue_id, exp_next_id);
        check("issue_instr", xif.issue_instr, instr);
        check("issue_rs", {xif.issue_rs_valid, xif.issue_rs}, {rsv, rs});
        for (int d = 0; d < delay; d++) begin
            @(negedge clk_i);
            if (!xif.issue_valid || xif.issue_instr !== instr || xif.issue_id !== exp_next_id ||
                xif.issue_rs !== rs || req_ready_o) stable = 0;
        end
        if (delay > 0) check("issue_hold", stable, 1);
        xif.issue_ready = 1'b1; xif.issue_accept = accept; xif.issue_writeback = wb;
        @(posedge clk_i); #1;
        xif.issue_ready = 1'b0;
        @(negedge clk_i);
        check("req_reject", req_reject_o, !accept);
        if (!accept) begin
            @(negedge clk_i);
            check("reject_pulse_end", req_reject_o, 0);
        end else begin
            unc_q.push_back(exp_next_id);
            exp_next_id = exp_next_id + 4'd1;
        end
    endtask

    task automatic commit(input bit kill);
        cmt_t c;
        @(posedge clk_i); #1;
        core_commit_valid_i = 1'b1; core_commit_kill_i = kill;
        if (unc_q.size() > 0) begin
            c.id = unc_q.pop_front(); c.kill = kill;
            exp_cmt_q.push_back(c);
        end
        @(posedge clk_i); #1;
        core_commit_valid_i = 1'b0;
    endtask

    task automatic send_result(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd,
                               input bit we, input bit exp_fwd);
        bit  ok = 0;
        wb_t w;
        @(posedge clk_i); #1;
        xif.result_valid = 1'b1; xif.result_id = id; xif.result_data = data;
        xif.result_rd = rd; xif.result_we = we;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_i);
            if (xif.result_ready) begin ok = 1; break; end
        end
        if (!ok) check("result_timeout", 0, 1);
        else if (exp_fwd) begin
            w.id = id; w.rd = rd; w.data = data;
            exp_wb_q.push_back(w);
        end
        @(posedge clk_i); #1;
        xif.result_valid = 1'b0;
    endtask

    task automatic offload(input logic [31:0] instr, input bit accept, input bit wb);
        do_request(instr, {32'd3, 32'd2, 32'd1}, 3'b111);
        do_issue(accept, wb, 0, instr, {32'd3, 32'd2, 32'd1}, 3'b111);
    endtask

    vec_t vecs[7];
    bit   seen;
    logic [3:0] vid;
`ifdef CV32E40X_XIF_OFFLOAD_RESULT_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    initial begin
        vecs[0] = '{32'h1234_5677, 32'h11, 32'h22, 32'h33, 3'b011, 0, 0, 0, 0, 32'h0, 5'd0, 0, 1, 0};
        vecs[1] = '{32'h0A00_0033, 32'd1, 32'd2, 32'd3, 3'b111, 1, 1, 0, 0, 32'hDEAD_BEEF, 5'd5, 1, 0, 1};
        vecs[2] = '{32'h0000_102B, 32'h5, 32'h6, 32'h7, 3'b001, 1, 0, 5, 0, 32'h0, 5'd0, 0, 0, 0};
        vecs[3] = '{32'h0000_202B, 32'h8, 32'h9, 32'hA, 3'b110, 1, 1, 0, 1, 32'hBAD0_BAD0, 5'd7, 1, 0, 0};
        vecs[4] = '{32'h0000_302B, 32'hB, 32'hC, 32'hD, 3'b111, 1, 1, 2, 0, 32'h1357_9BDF, 5'd9, 0, 0, 0};
        vecs[5] = '{32'h0000_402B, 32'hE, 32'hF, 32'h10, 3'b100, 1, 1, 0, 0, 32'h0000_0000, 5'd31, 1, 0, 1};
        vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 3'b010, 1, 1, 1, 0, 32'hFFFF_FFFF, 5'd0, 1, 0, 1};

        xif.issue_ready = 1'b0; xif.issue_accept = 1'b0; xif.issue_writeback = 1'b0;
        xif.result_valid = 1'b0; xif.result_id = '0; xif.result_data = '0;
        xif.result_rd = '0; xif.result_we = 1'b0;
        apply_reset();

        @(negedge clk_i);
        check("reset_ctrl", {req_ready_o, xif.issue_valid, xif.commit_valid, req_reject_o,
                             wb_valid_o, err_o, xif.result_ready}, 7'b1000001);
        check("reset_ids", {xif.issue_id, xif.commit_id, wb_id_o, wb_rd_o}, '0);
        check("reset_data", wb_data_o, 32'h0);

        for (int v = 0; v < 7; v++) begin
            vid = exp_next_id;
            do_request(vecs[v].instr, {vecs[v].rs3, vecs[v].rs2, vecs[v].rs1}, vecs[v].rsv);
            do_issue(vecs[v].accept, vecs[v].wb, vecs[v].delay, vecs[v].instr,
                     {vecs[v].rs3, vecs[v].rs2, vecs[v].rs1}, vecs[v].rsv);
            if (vecs[v].accept) begin
                commit(vecs[v].kill);
                if (vecs[v].wb && !vecs[v].kill)
                    send_result(vid, vecs[v].data, vecs[v].rd, vecs[v].we, vecs[v].exp_wb);
            end
            repeat (2) @(posedge clk_i);
            @(negedge clk_i);
            check("table_empty", req_ready_o, 1);
        end

        // Table full: third request waits until the oldest entry is killed.
        apply_reset();
        offload(32'hA1, 1, 1);
        offload(32'hA2, 1, 1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b1; req_instr_i = 32'hA3;
        seen = 0;
        repeat (4) begin @(negedge clk_i); if (req_ready_o) seen = 1; end
        check("full_ready", seen, 0);
        req_valid_i = 1'b0;
        commit(1);
        @(negedge clk_i);
        check("ready_after_kill", req_ready_o, 1);
        offload(32'hA3, 1, 1);
        commit(1);
        do_request(32'hA4, {32'd3, 32'd2, 32'd1}, 3'b111);
        @(negedge clk_i);
        check("pre_reset_issue", xif.issue_valid, 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {xif.issue_valid, req_ready_o, wb_valid_o, xif.commit_valid}, 4'b0100);
        model_reset();
        @(posedge clk_i); #1 rst_n = 1'b1;

        // Writeback backpressure stalls a second result.
        offload(32'hB1, 1, 1);
        offload(32'hB2, 1, 1);
        commit(0);
        commit(0);
        wb_ready_i = 1'b0;
        send_result(4'd0, 32'hCAFE_0001, 5'd3, 1, 1);
        fork
            send_result(4'd1, 32'hCAFE_0002, 5'd4, 1, 1);
            begin
                repeat (3) @(negedge clk_i);
                check("res_stall", xif.result_ready, 0);
                check("wb_hold", {wb_valid_o, wb_data_o}, {1'b1, 32'hCAFE_0001});
                @(posedge clk_i); #1 wb_ready_i = 1'b1;
            end
        join
        repeat (3) @(posedge clk_i);

        // Id wrap across 17 accepted/committed instructions.
        apply_reset();
        for (int k = 0; k < 17; k++) begin
            offload(32'hC000_0000 + k, 1, 0);
            commit(0);
        end

`ifdef CV32E40X_XIF_OFFLOAD_RESULT_CHECK_EN
        send_result(4'd7, 32'h7777_7777, 5'd7, 1, 0);
`endif
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("err_o", err_o, EXP_ERR);
        check("cmt_q_drained", exp_cmt_q.size(), 0);
        check("wb_q_drained", exp_wb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
